simon_sequence_player: RTL

- Read side of the Simon pattern memory.
- On a start request it reads stored colour codes 0..length-1 in order and flashes the matching LED (g1..g4) for a fixed on-time, then holds all LEDs dark for a fixed off-time.
- When the last step finishes it issues a done pulse.
- Sits between the sequence RAM (written by the data path as rounds grow) and the LED outputs; the game controller issues start/abort.

---
 rtl/simon_sequence_player.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/simon_sequence_player.sv
// Simon pattern playback: walks the sequence RAM, flashes one LED per stored
// colour code with a fixed on/off cadence, and pulses done at the end.
module simon_sequence_player #(
    parameter int AW         = 5,
    parameter int ON_CYCLES  = 20,
    parameter int OFF_CYCLES = 10,
    parameter int CW         = 16
) (
    input  logic          SYS_CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   length,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [1:0]    rd_data,
    output logic          g1,
    output logic          g2,
    output logic          g3,
    output logic          g4,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] ON    = 3'd2;
    localparam logic [2:0] OFF   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);

    function automatic logic [3:0] led_decode(input logic [1:0] code);
        logic [3:0] led;
        case (code)
            2'b00:   led = 4'b0001;
            2'b01:   led = 4'b0010;
            2'b10:   led = 4'b0100;
            2'b11:   led = 4'b1000;
            default: led = 4'b0000;
        endcase
        return led;
    endfunction

    logic [2:0]    state_r,   state_s;
    logic [AW:0]   index_r,   index_s;
    logic [AW:0]   len_r,     len_s;
    logic [CW-1:0] cnt_r,     cnt_s;
    logic [3:0]    led_r,     led_s;
    logic          rd_en_r,   rd_en_s;
    logic [AW-1:0] rd_addr_r, rd_addr_s;
    logic          busy_r,    busy_s;
    logic          done_r,    done_s;
    logic [AW:0]   index_inc_s;

    assign index_inc_s = index_r + {{AW{1'b0}}, 1'b1};

    // Next-state and next-output logic; every output is the registered copy.
    always_comb begin
        state_s   = state_r;
        index_s   = index_r;
        len_s     = len_r;
        cnt_s     = cnt_r;
        led_s     = led_r;
        rd_en_s   = 1'b0;
        rd_addr_s = rd_addr_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        if (abort && (state_r != IDLE)) begin
            state_s   = IDLE;
            index_s   = {(AW+1){1'b0}};
            cnt_s     = {CW{1'b0}};
            led_s     = 4'b0000;
            rd_addr_s = {AW{1'b0}};
            busy_s    = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_s     = length;
                        index_s   = {(AW+1){1'b0}};
                        rd_addr_s = {AW{1'b0}};
                        busy_s    = 1'b1;
                        if (length == {(AW+1){1'b0}}) begin
                            state_s = DONE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = FETCH;
                            rd_en_s = 1'b1;
                        end
                    end else begin
                        busy_s = 1'b0;
                    end
                end
                FETCH: begin
                    // rd_data for the current address is valid while in FETCH
                    state_s = ON;
                    led_s   = led_decode(rd_data);
                    cnt_s   = ON_LAST;
                end
                ON: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_s = OFF;
                        led_s   = 4'b0000;
                        cnt_s   = OFF_LAST;
                    end else begin
                        cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                OFF: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        if (index_inc_s < len_r) begin
                            index_s   = index_inc_s;
                            rd_addr_s = index_inc_s[AW-1:0];
                            rd_en_s   = 1'b1;
                            state_s   = FETCH;
                        end else begin
                            state_s = DONE;
                            done_s  = 1'b1;
                        end
                    end else begin
                        cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    cnt_s   = {CW{1'b0}};
                end
                default: begin
                    state_s = IDLE;
                    led_s   = 4'b0000;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            state_r   <= IDLE;
            index_r   <= {(AW+1){1'b0}};
            len_r     <= {(AW+1){1'b0}};
            cnt_r     <= {CW{1'b0}};
            led_r     <= 4'b0000;
            rd_en_r   <= 1'b0;
            rd_addr_r <= {AW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            index_r   <= index_s;
            len_r     <= len_s;
            cnt_r     <= cnt_s;
            led_r     <= led_s;
            rd_en_r   <= rd_en_s;
            rd_addr_r <= rd_addr_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign rd_en   = rd_en_r;
    assign rd_addr = rd_addr_r;
    assign g1      = led_r[0];
    assign g2      = led_r[1];
    assign g3      = led_r[2];
    assign g4      = led_r[3];
    assign busy    = busy_r;
    assign done    = done_r;

endmodule
